// File: rtl/dma_dev_arbiter.sv
// -----------------------------------------------------------------------------
// dma_dev_arbiter
//
// Round-robin arbiter that shares the single device-side port of the DMA
// controller among NUM_DEV peripheral requesters. One requester is granted at
// a time. Its transfer descriptor is latched, a one-cycle rqst pulse is sent to
// the DMA, and the DMA data/ack handshake is routed to the granted device only.
// The grant is released on the DMA end_flag. A watchdog aborts transfers that
// stop making progress.
//
// Handshake semantics:
//   req_rqst[i] is a level request. The device holds it until it sees
//   req_end[i] or req_err[i], and drops it within one cycle of either.
//   Toward the DMA, rqst is a single-cycle pulse. The descriptor
//   (num_words/start_addr/rd_wr) is valid from that pulse until the grant is
//   released. Data moves only in cycles where the ack is high: dev_ack
//   qualifies dev_in (device -> DMA), and dma_ack / req_dma_ack qualifies
//   dev_out / req_dev_out (DMA -> device). end_flag marks the end of the
//   transfer.
//
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   req_*  (inputs)  per-device request, direction, descriptor, ack, data
//   req_grant        one-hot registered grant
//   req_dma_ack      DMA ack routed to the granted device
//   req_end          DMA end_flag routed to the granted device
//   req_err          one-cycle watchdog-abort pulse to the granted device
//   req_dev_out      DMA data, broadcast to all devices
//   num_words, start_addr, rd_wr, rqst, dev_ack, dev_in
//                    DMA-side request port
//   dma_ack, dev_out, end_flag
//                    DMA-side responses
//   dma_abort        held high for 2 cycles on watchdog expiry; ORed into the
//                    DMA controller reset by the integrator
//   busy             FSM not in IDLE
//   state_dbg        current FSM state encoding
// -----------------------------------------------------------------------------
module dma_dev_arbiter #(
   parameter int NUM_DEV   = 4,
   parameter int ADD_LEN   = 16,
   parameter int DATA_LEN  = 16,
   parameter int TIMEOUT_W = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_DEV-1:0]            req_rqst,
   input  logic [NUM_DEV-1:0]            req_rd_wr,
   input  logic [NUM_DEV*ADD_LEN-1:0]    req_num_words,
   input  logic [NUM_DEV*(ADD_LEN+1)-1:0] req_start_addr,
   input  logic [NUM_DEV-1:0]            req_dev_ack,
   input  logic [NUM_DEV*DATA_LEN-1:0]   req_dev_in,
   output logic [NUM_DEV-1:0]            req_grant,
   output logic [NUM_DEV-1:0]            req_dma_ack,
   output logic [NUM_DEV-1:0]            req_end,
   output logic [NUM_DEV-1:0]            req_err,
   output logic [DATA_LEN-1:0]           req_dev_out,
   output logic [ADD_LEN-1:0]            num_words,
   output logic [ADD_LEN:0]              start_addr,
   output logic                          rd_wr,
   output logic                          rqst,
   output logic                          dev_ack,
   output logic [DATA_LEN-1:0]           dev_in,
   input  logic                          dma_ack,
   input  logic [DATA_LEN-1:0]           dev_out,
   input  logic                          end_flag,
   output logic                          dma_abort,
   output logic                          busy,
   output logic [2:0]                    state_dbg
);

   localparam int IW = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
   localparam logic [IW-1:0] LAST_RST = IW'(NUM_DEV - 1);

   typedef enum logic [2:0] {
      S_WAIT_DMA = 3'd0,
      S_IDLE     = 3'd1,
      S_REQ      = 3'd2,
      S_BUSY     = 3'd3,
      S_RELEASE  = 3'd4,
      S_ABORT    = 3'd5
   } state_t;

   state_t               state;
   logic                 phase;     // second-cycle marker for WAIT_DMA and ABORT
   logic [IW-1:0]        last;      // most recent winner
   logic [TIMEOUT_W-1:0] wdog;

   logic                 win_valid;
   logic [IW-1:0]        win_idx;
   logic [IW-1:0]        cand;

   // Round-robin search starting at last+1. The loop runs from the farthest
   // candidate down to the nearest, so the nearest requesting device is the
   // one left in win_idx.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = NUM_DEV; k >= 1; k--) begin
         cand = IW'((int'(last) + k) % NUM_DEV);
         if (req_rqst[cand]) begin
            win_valid = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Routing toward the DMA: only the granted device's ack and data pass.
   always_comb begin
      dev_ack = |(req_dev_ack & req_grant);
      dev_in  = '0;
      for (int i = 0; i < NUM_DEV; i++) begin
         if (req_grant[i]) begin
            dev_in = dev_in | req_dev_in[i*DATA_LEN +: DATA_LEN];
         end
      end
   end

   assign req_dma_ack = req_grant & {NUM_DEV{dma_ack}};
   assign req_end     = req_grant & {NUM_DEV{end_flag}};
   assign req_dev_out = dev_out;
   assign busy        = (state != S_IDLE);
   assign state_dbg   = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_WAIT_DMA;
         phase      <= 1'b0;
         last       <= LAST_RST;
         wdog       <= '0;
         req_grant  <= '0;
         req_err    <= '0;
         rqst       <= 1'b0;
         dma_abort  <= 1'b0;
         num_words  <= '0;
         start_addr <= '0;
         rd_wr      <= 1'b0;
      end else begin
         req_err <= '0;
         case (state)
            // Give the DMA controller time to leave its own reset state.
            S_WAIT_DMA: begin
               if (phase) begin
                  phase <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  phase <= 1'b1;
               end
            end
            S_IDLE: begin
               if (win_valid) begin
                  state      <= S_REQ;
                  last       <= win_idx;
                  req_grant  <= NUM_DEV'(1) << win_idx;
                  num_words  <= req_num_words[win_idx*ADD_LEN +: ADD_LEN];
                  start_addr <= req_start_addr[win_idx*(ADD_LEN+1) +: ADD_LEN+1];
                  rd_wr      <= req_rd_wr[win_idx];
                  rqst       <= 1'b1;
               end
            end
            S_REQ: begin
               rqst  <= 1'b0;
               wdog  <= '0;
               state <= S_BUSY;
            end
            // end_flag takes priority over a watchdog expiry in the same cycle.
            S_BUSY: begin
               if (end_flag) begin
                  state <= S_RELEASE;
               end else if (&wdog) begin
                  state     <= S_ABORT;
                  req_err   <= req_grant;
                  dma_abort <= 1'b1;
                  phase     <= 1'b0;
               end else if (dma_ack) begin
                  wdog <= '0;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            S_RELEASE: begin
               req_grant <= '0;
               state     <= S_IDLE;
            end
            // The grant is held through the abort so req_err reaches the
            // device that owned the transfer, and it is dropped on exit.
            S_ABORT: begin
               if (phase) begin
                  phase     <= 1'b0;
                  dma_abort <= 1'b0;
                  req_grant <= '0;
                  state     <= S_WAIT_DMA;
               end else begin
                  phase <= 1'b1;
               end
            end
            default: begin
               state <= S_WAIT_DMA;
               phase <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dma_dev_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dma_dev_arbiter
//
// Bench for dma_dev_arbiter. The DUT is built with a 4-bit watchdog so that
// expiry happens in a short run. The bench plays both the requesting devices
// and the DMA controller. The expected grant and descriptor of every transfer
// are queued when the requests are driven. They are popped and compared when
// the DUT issues its rqst pulse.
// -----------------------------------------------------------------------------
module tb_dma_dev_arbiter;

   localparam int NUM_DEV = 4;
   localparam int AL      = 16;
   localparam int DL      = 16;
   localparam int TW      = 4;
   localparam int EW      = NUM_DEV + AL + (AL + 1) + 1;

   logic                      clk = 1'b0;
   logic                      reset;
   logic [NUM_DEV-1:0]        req_rqst;
   logic [NUM_DEV-1:0]        req_rd_wr;
   logic [NUM_DEV*AL-1:0]     req_num_words;
   logic [NUM_DEV*(AL+1)-1:0] req_start_addr;
   logic [NUM_DEV-1:0]        req_dev_ack;
   logic [NUM_DEV*DL-1:0]     req_dev_in;
   logic [NUM_DEV-1:0]        req_grant;
   logic [NUM_DEV-1:0]        req_dma_ack;
   logic [NUM_DEV-1:0]        req_end;
   logic [NUM_DEV-1:0]        req_err;
   logic [DL-1:0]             req_dev_out;
   logic [AL-1:0]             num_words;
   logic [AL:0]               start_addr;
   logic                      rd_wr;
   logic                      rqst;
   logic                      dev_ack;
   logic [DL-1:0]             dev_in;
   logic                      dma_ack;
   logic [DL-1:0]             dev_out;
   logic                      end_flag;
   logic                      dma_abort;
   logic                      busy;
   logic [2:0]                state_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   logic [EW-1:0] exp_q[$];
   logic [AL-1:0] d_nw[NUM_DEV];
   logic [AL:0]   d_sa[NUM_DEV];
   logic          d_rw[NUM_DEV];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   dma_dev_arbiter #(
      .NUM_DEV(NUM_DEV), .ADD_LEN(AL), .DATA_LEN(DL), .TIMEOUT_W(TW)
   ) dut (
      .clk(clk), .reset(reset),
      .req_rqst(req_rqst), .req_rd_wr(req_rd_wr),
      .req_num_words(req_num_words), .req_start_addr(req_start_addr),
      .req_dev_ack(req_dev_ack), .req_dev_in(req_dev_in),
      .req_grant(req_grant), .req_dma_ack(req_dma_ack), .req_end(req_end),
      .req_err(req_err), .req_dev_out(req_dev_out),
      .num_words(num_words), .start_addr(start_addr), .rd_wr(rd_wr),
      .rqst(rqst), .dev_ack(dev_ack), .dev_in(dev_in),
      .dma_ack(dma_ack), .dev_out(dev_out), .end_flag(end_flag),
      .dma_abort(dma_abort), .busy(busy), .state_dbg(state_dbg)
   );

   // ---------------- driver tasks ----------------
   task automatic tick;
      @(negedge clk);
   endtask

   task automatic set_desc(input int d, input logic rw, input logic [AL-1:0] nw,
                           input logic [AL:0] sa);
      d_nw[d] = nw;
      d_sa[d] = sa;
      d_rw[d] = rw;
      req_rd_wr[d] = rw;
      req_num_words[d*AL +: AL] = nw;
      req_start_addr[d*(AL+1) +: AL+1] = sa;
   endtask

   task automatic push_exp(input int d);
      logic [NUM_DEV-1:0] g;
      g = '0;
      g[d] = 1'b1;
      exp_q.push_back({g, d_nw[d], d_sa[d], d_rw[d]});
   endtask

   task automatic do_reset;
      req_rqst = '0;
      dma_ack  = 1'b0;
      end_flag = 1'b0;
      reset    = 1'b0;
      tick;
      tick;
      reset = 1'b1;
      tick;
      tick;
      tick;
      exp_q.delete();
   endtask

   // Waits for rqst, checks the granted descriptor against the queue, then
   // plays the DMA side: nwords acked data beats followed by end_flag.
   task automatic run_transfer(input int dev, input int nwords, input bit drop,
                               input bit change_nw, output int lat);
      logic [EW-1:0]      exp_v;
      logic [EW-1:0]      got_v;
      logic [NUM_DEV-1:0] g;
      logic [AL-1:0]      nw;
      lat = 0;
      while (rqst !== 1'b1 && lat < 30) begin
         tick;
         lat++;
      end
      n_checks++;
      if (rqst !== 1'b1) begin
         n_fail++;
         $display("FAIL rqst_wait dev %0d: rqst=%b after %0d cycles, required 1", dev, rqst, lat);
         return;
      end
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: rqst with grant %b, required no rqst", req_grant);
         return;
      end
      exp_v = exp_q.pop_front();
      got_v = {req_grant, num_words, start_addr, rd_wr};
      if (got_v !== exp_v) begin
         n_fail++;
         $display("FAIL grant_desc dev %0d: got %h required %h", dev, got_v, exp_v);
      end
      g  = exp_v[1 + (AL+1) + AL +: NUM_DEV];
      nw = exp_v[1 + (AL+1) +: AL];
      if (change_nw) req_num_words[dev*AL +: AL] = 16'd3;
      tick;
      n_checks++;
      if (rqst !== 1'b0) begin
         n_fail++;
         $display("FAIL rqst_pulse dev %0d: rqst=%b, required 0", dev, rqst);
      end
      for (int w = 0; w < nwords; w++) begin
         req_dev_ack = NUM_DEV'($urandom_range(0, 15));
         req_dev_in  = {NUM_DEV{DL'($urandom_range(0, 65535))}} ^ NUM_DEV*DL'($urandom_range(0, 65535));
         dev_out     = DL'($urandom_range(0, 65535));
         dma_ack     = 1'b1;
         #1;
         n_checks++;
         if (dev_ack !== req_dev_ack[dev]) begin
            n_fail++;
            $display("FAIL dev_ack_route dev %0d: got %b required %b", dev, dev_ack, req_dev_ack[dev]);
         end
         n_checks++;
         if (dev_in !== req_dev_in[dev*DL +: DL]) begin
            n_fail++;
            $display("FAIL dev_in_route dev %0d: got %h required %h", dev, dev_in, req_dev_in[dev*DL +: DL]);
         end
         n_checks++;
         if (req_dma_ack !== g || req_dev_out !== dev_out) begin
            n_fail++;
            $display("FAIL dma_ack_route dev %0d: got %b/%h required %b/%h", dev, req_dma_ack, req_dev_out, g, dev_out);
         end
         n_checks++;
         if (num_words !== nw) begin
            n_fail++;
            $display("FAIL desc_hold dev %0d: num_words %h required %h", dev, num_words, nw);
         end
         tick;
         dma_ack = 1'b0;
      end
      end_flag = 1'b1;
      #1;
      n_checks++;
      if (req_end !== g || req_err !== '0 || num_words !== nw) begin
         n_fail++;
         $display("FAIL end_route dev %0d: req_end %b req_err %b nw %h required %b 0000 %h", dev, req_end, req_err, num_words, g, nw);
      end
      tick;
      end_flag = 1'b0;
      if (drop) req_rqst[dev] = 1'b0;
      if (change_nw) req_num_words[dev*AL +: AL] = d_nw[dev];
      n_checks++;
      if (req_grant !== g || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL release_hold dev %0d: grant %b busy %b required %b 1", dev, req_grant, busy, g);
      end
      tick;
      n_checks++;
      if (req_grant !== '0 || busy !== 1'b0 || state_dbg !== 3'd1) begin
         n_fail++;
         $display("FAIL release_clear dev %0d: grant %b busy %b state %0d required 0 0 1", dev, req_grant, busy, state_dbg);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      req_rqst    = '1;
      req_dev_ack = '1;
      dma_ack     = 1'b1;
      end_flag    = 1'b1;
      #1;
      n_checks++;
      if ({req_grant, req_err, rqst, dma_abort, rd_wr} !== '0 || num_words !== '0 || start_addr !== '0) begin
         n_fail++;
         $display("FAIL reset_regs: grant %b err %b rqst %b abort %b nw %h sa %h rw %b required all 0",
                  req_grant, req_err, rqst, dma_abort, num_words, start_addr, rd_wr);
      end
      n_checks++;
      if (dev_ack !== 1'b0 || req_dma_ack !== '0 || req_end !== '0 || busy !== 1'b1 || state_dbg !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_comb: dev_ack %b dma_ack %b end %b busy %b state %0d required 0 0000 0000 1 0",
                  dev_ack, req_dma_ack, req_end, busy, state_dbg);
      end
      req_rqst    = '0;
      req_dev_ack = '0;
      dma_ack     = 1'b0;
      end_flag    = 1'b0;
      tick;
      reset = 1'b1;
      tick;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL wait_dma_len: busy %b after 1 cycle, required 1", busy);
      end
      tick;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL wait_dma_len: busy %b after 2 cycles, required 0", busy);
      end
   endtask

   task automatic test_single_read;
      int lat;
      do_reset();
      set_desc(2, 1'b1, 16'd4, 17'h00200);
      push_exp(2);
      req_rqst[2] = 1'b1;
      run_transfer(2, 4, 1'b1, 1'b0, lat);
      n_checks++;
      if (lat != 1) begin
         n_fail++;
         $display("FAIL req_latency: got %0d cycles required 1", lat);
      end
   endtask

   task automatic test_round_robin;
      int lat;
      do_reset();
      set_desc(0, 1'b1, 16'd2, 17'h01000);
      set_desc(1, 1'b0, 16'd3, 17'h02002);
      set_desc(3, 1'b1, 16'd1, 17'h1fffe);
      for (int r = 0; r < 2; r++) begin
         push_exp(0);
         push_exp(1);
         push_exp(3);
      end
      req_rqst = 4'b1011;
      run_transfer(0, 2, 1'b0, 1'b0, lat);
      run_transfer(1, 3, 1'b0, 1'b0, lat);
      run_transfer(3, 1, 1'b0, 1'b0, lat);
      run_transfer(0, 2, 1'b0, 1'b0, lat);
      run_transfer(1, 3, 1'b0, 1'b0, lat);
      run_transfer(3, 1, 1'b1, 1'b0, lat);
      req_rqst = '0;
      tick;
   endtask

   task automatic test_desc_hold;
      int lat;
      do_reset();
      set_desc(1, 1'b0, 16'd8, 17'h00444);
      push_exp(1);
      req_rqst[1] = 1'b1;
      run_transfer(1, 8, 1'b1, 1'b1, lat);
   endtask

   task automatic test_zero_words;
      int lat;
      do_reset();
      set_desc(0, 1'b0, 16'd0, 17'h00040);
      push_exp(0);
      req_rqst[0] = 1'b1;
      run_transfer(0, 0, 1'b1, 1'b0, lat);
   endtask

   task automatic test_timeout;
      logic [EW-1:0] exp_v;
      int cnt;
      int lat;
      do_reset();
      req_dev_ack = '0;
      set_desc(2, 1'b1, 16'd5, 17'h00300);
      set_desc(3, 1'b0, 16'd2, 17'h00500);
      push_exp(2);
      push_exp(3);
      req_rqst = 4'b1100;
      cnt = 0;
      while (rqst !== 1'b1 && cnt < 30) begin
         tick;
         cnt++;
      end
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({req_grant, num_words, start_addr, rd_wr} !== exp_v) begin
         n_fail++;
         $display("FAIL timeout_grant: got %h required %h", {req_grant, num_words, start_addr, rd_wr}, exp_v);
      end
      cnt = 0;
      while (req_err === '0 && cnt < 40) begin
         tick;
         cnt++;
      end
      n_checks++;
      if (cnt != (1 << TW) + 1 || req_err !== 4'b0100 || dma_abort !== 1'b1) begin
         n_fail++;
         $display("FAIL watchdog_expiry: err %b abort %b after %0d cycles, required 0100 1 after %0d",
                  req_err, dma_abort, cnt, (1 << TW) + 1);
      end
      req_rqst[2] = 1'b0;
      tick;
      n_checks++;
      if (dma_abort !== 1'b1 || req_err !== '0) begin
         n_fail++;
         $display("FAIL abort_len: abort %b err %b in second cycle, required 1 0000", dma_abort, req_err);
      end
      tick;
      n_checks++;
      if (dma_abort !== 1'b0 || req_grant !== '0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_exit: abort %b grant %b busy %b required 0 0000 1", dma_abort, req_grant, busy);
      end
      run_transfer(3, 2, 1'b1, 1'b0, lat);
      n_checks++;
      if (lat != 3) begin
         n_fail++;
         $display("FAIL post_abort_latency: got %0d cycles required 3", lat);
      end
   endtask

   task automatic test_reset_mid_busy;
      logic [EW-1:0] exp_v;
      int cnt;
      int lat;
      do_reset();
      set_desc(0, 1'b1, 16'd6, 17'h00a00);
      set_desc(3, 1'b0, 16'd7, 17'h00b00);
      push_exp(0);
      req_rqst = 4'b1001;
      cnt = 0;
      while (rqst !== 1'b1 && cnt < 30) begin
         tick;
         cnt++;
      end
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({req_grant, num_words, start_addr, rd_wr} !== exp_v) begin
         n_fail++;
         $display("FAIL pre_reset_grant: got %h required %h", {req_grant, num_words, start_addr, rd_wr}, exp_v);
      end
      tick;
      req_dev_ack = '1;
      reset = 1'b0;
      #1;
      n_checks++;
      if ({req_grant, req_err, rqst, dma_abort, rd_wr, dev_ack} !== '0 || num_words !== '0 ||
          start_addr !== '0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL async_reset: grant %b err %b rqst %b abort %b rw %b dev_ack %b nw %h sa %h busy %b",
                  req_grant, req_err, rqst, dma_abort, rd_wr, dev_ack, num_words, start_addr, busy);
      end
      tick;
      reset = 1'b1;
      push_exp(0);
      run_transfer(0, 1, 1'b1, 1'b0, lat);
      n_checks++;
      if (lat != 3) begin
         n_fail++;
         $display("FAIL post_reset_latency: got %0d cycles required 3", lat);
      end
      req_rqst = '0;
      tick;
   endtask

   // ---------------- main sequence and report ----------------
   initial begin
      reset          = 1'b0;
      req_rqst       = '0;
      req_rd_wr      = '0;
      req_num_words  = '0;
      req_start_addr = '0;
      req_dev_ack    = '0;
      req_dev_in     = '0;
      dma_ack        = 1'b0;
      dev_out        = '0;
      end_flag       = 1'b0;
      for (int i = 0; i < NUM_DEV; i++) begin
         d_nw[i] = '0;
         d_sa[i] = '0;
         d_rw[i] = 1'b0;
      end
      tick;
      test_reset();
      test_single_read();
      test_round_robin();
      test_desc_hold();
      test_zero_words();
      test_timeout();
      test_reset_mid_busy();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_leftover: %0d entries, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dma_dev_arbiter.md
# dma_dev_arbiter

Round-robin arbiter that shares the single device-side port of `dma_controller` among up to `NUM_DEV` peripheral requesters. It sits between the peripherals and the DMA controller. It grants one requester at a time and latches that requester's transfer descriptor (`num_words`, `start_addr`, `rd_wr`). It then issues a one-cycle `rqst` pulse to the DMA and routes the data/ack handshake of the granted device only. The grant is released on the DMA `end_flag`. A watchdog aborts hung transfers.

## Interface
Parameters:
- `NUM_DEV`, 4: number of requesters (2..8).
- `ADD_LEN`, 16: address/word-count width; must match the DMA controller.
- `DATA_LEN`, 16: data width; must match the DMA controller.
- `TIMEOUT_W`, 16: watchdog counter width; timeout fires at 2^TIMEOUT_W-1 cycles.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_rqst`  in  NUM_DEV  per-device level request.
- `req_rd_wr`  in  NUM_DEV  per-device direction (1 = memory read to device).
- `req_num_words`  in  NUM_DEV*ADD_LEN  per-device word count, slice i = device i.
- `req_start_addr`  in  NUM_DEV*(ADD_LEN+1)  per-device byte start address.
- `req_dev_ack`  in  NUM_DEV  per-device ready/ack toward the DMA.
- `req_dev_in`  in  NUM_DEV*DATA_LEN  per-device write data.
- `req_grant`  out  NUM_DEV  one-hot grant.
- `req_dma_ack`  out  NUM_DEV  DMA `dma_ack`, routed to the granted device only.
- `req_end`  out  NUM_DEV  DMA `end_flag`, routed to the granted device only.
- `req_err`  out  NUM_DEV  one-cycle watchdog-abort pulse to the granted device.
- `req_dev_out`  out  DATA_LEN  DMA `dev_out`, broadcast unmodified; qualified by `req_dma_ack`.
- `num_words`  out  ADD_LEN  to DMA; latched descriptor.
- `start_addr`  out  ADD_LEN+1  to DMA; latched descriptor.
- `rd_wr`  out  1  to DMA; latched descriptor.
- `rqst`  out  1  to DMA; one-cycle pulse.
- `dev_ack`  out  1  to DMA; `req_dev_ack` of the granted device.
- `dev_in`  out  DATA_LEN  to DMA; `req_dev_in` slice of the granted device.
- `dma_ack`  in  1  from DMA.
- `dev_out`  in  DATA_LEN  from DMA.
- `end_flag`  in  1  from DMA.
- `dma_abort`  out  1  active-high; the integrator ORs it into the DMA controller reset.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
FSM states and transitions:
- **WAIT_DMA**: entered on reset and after an abort. Stays 2 cycles, then goes to IDLE. This gives the DMA time to pass its RESET state.
- **IDLE**: if any `req_rqst` bit is set, selects the winner and goes to REQ.
- **REQ**: asserts `rqst` = 1 for one cycle, then goes to BUSY.
- **BUSY**: waits for `end_flag`. When `end_flag` = 1, goes to RELEASE. When the watchdog expires, goes to ABORT.
- **RELEASE**: clears the grant, then goes to IDLE.
- **ABORT**: holds `dma_abort` = 1 for 2 cycles, then goes to WAIT_DMA.

Arbitration:
- Winner is the first set `req_rqst` bit, searching upward from `last+1` modulo NUM_DEV.
- `last` resets to NUM_DEV-1, so device 0 has first priority out of reset.
- `last` updates to the winner on the IDLE->REQ edge.

Descriptor handling:
- The winner's `num_words`, `start_addr` and `rd_wr` are registered on the IDLE->REQ edge.
- They are held unchanged until the RELEASE->IDLE edge, regardless of requester input changes.
- `req_grant` is registered: set on IDLE->REQ, cleared on RELEASE->IDLE.

Routing (combinational, qualified by `req_grant`):
- `dev_ack` and `dev_in` come from the granted device.
- `req_dma_ack` and `req_end` go to the granted bit only.
- Ungranted devices see 0 on `req_dma_ack`, `req_end` and `req_err`.
- `dev_ack` = 0 when nothing is granted.

Requester rules:
- A device must drop `req_rqst` within one cycle of seeing `req_end` or `req_err`.
- A request still high at the next IDLE is treated as a new request and competes round-robin.
- A request dropped before grant is simply not served.

Watchdog:
- TIMEOUT_W counter, cleared on entry to BUSY.
- Increments every cycle in BUSY; resets to 0 whenever `dma_ack` = 1.
- Expiry (all ones, `end_flag` = 0) pulses `req_err` of the granted device and enters ABORT.
- `end_flag` and expiry in the same cycle: `end_flag` wins; normal completion.

Zero-word descriptors:
- `num_words` = 0 is forwarded unchanged.
- The DMA terminates immediately with `end_flag` (security-violation path); the arbiter treats this as normal completion.

Reset:
- Reset asserted mid-transfer returns the FSM to WAIT_DMA immediately.
- All registered outputs clear; `last` returns to NUM_DEV-1.

## Timing
- Reset values: `req_grant`, `req_err`, `rqst`, `dma_abort` = 0; `num_words` = 0, `start_addr` = 0, `rd_wr` = 0. Combinational outputs follow from grant = 0, except `busy` = 1 because the FSM is in WAIT_DMA.
- Request-to-`rqst` latency (from IDLE): request sampled high at edge N; `req_grant` and descriptor valid after N; `rqst` high for the cycle after N only.
- The DMA latches the descriptor in GET_REGS, one cycle after `rqst`. The descriptor is stable throughout.
- `req_end` is combinational with `end_flag`. RELEASE follows one cycle later; IDLE follows the cycle after that.
- Minimum gap between consecutive `rqst` pulses: `rqst`, BUSY (>=1 cycle), RELEASE, IDLE, REQ. That is at least 4 cycles.

## Test plan
- Single device 2 requests read, 4 words at 0x0200 -> `req_grant` = 0b0100 one cycle after request; one `rqst` pulse; DMA sees `num_words` = 4, `start_addr` = 0x0200, `rd_wr` = 1; `req_end[2]` pulses; grant clears 2 cycles later.
- Devices 0, 1, 3 request simultaneously and continuously -> grants in order 0, 1, 3, 0, 1, 3; no two grants overlap; `rqst` pulses once per grant.
- Device 1 changes `req_num_words` from 8 to 3 mid-transfer -> DMA-side `num_words` stays 8 until release.
- Device 0 requests write with `num_words` = 0 -> `end_flag` within 3 cycles; `req_end[0]` pulses; no `req_err`.
- Stalled transfer with TIMEOUT_W = 4: `dev_ack` held 0, no `dma_ack` -> after 15 BUSY cycles `req_err[g]` pulses; `dma_abort` high 2 cycles; 2 WAIT_DMA cycles; next pending request is then granted.
- `reset` driven low during BUSY -> all outputs return to reset values asynchronously; after release, device 0 wins a 0-vs-3 tie.
